atree_accum_ctrl: RTL
=====================

Name: atree_accum_ctrl

Overview:
Sequencer that reduces a long unsigned vector, delivered as NUM_INPUTS-wide beats, to a single sum. It feeds each accepted beat through one instance of the existing adder tree (atree) and registers the tree result. It then accumulates successive tree results into a wide accumulator and presents the final sum on a valid/ready output. It sits between a vector source (stream with valid/ready) and any consumer of reductions (dot-product / pooling stages).

Parameters:
IN_WIDTH, 32, width in bits of each unsigned input element
LEVELS, 4, adder-tree depth; NUM_INPUTS = 2**LEVELS elements per beat (derived, not overridable)
ACC_WIDTH, 48, accumulator/result width; must be >= IN_WIDTH+LEVELS (elaboration-time check)
LEN_WIDTH, 16, width of the beat-count configuration

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a reduction; sampled only in IDLE
cfg_len  in  LEN_WIDTH  number of beats in the vector; latched with start
busy  out  1  high in any state other than IDLE
in_valid  in  1  beat available
in_ready  out  1  controller accepts beat this cycle
in_data  in  NUM_INPUTS x IN_WIDTH  packed beat; element n at [n]
out_valid  out  1  result available
out_ready  in  1  consumer takes result
out_sum  out  ACC_WIDTH  accumulated sum, modulo 2**ACC_WIDTH
out_overflow  out  1  sticky: a carry out of ACC_WIDTH occurred during this reduction

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, in_ready=0, out_valid=0, out_sum=0, out_overflow=0; beat counter, pipe register, pipe_valid and accumulator cleared. Reset applies mid-operation: the partial result is discarded with no output.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. On start=1:
  - latch cfg_len into remaining; clear acc and overflow.
  - cfg_len != 0 -> RUN; cfg_len = 0 -> DONE (out_sum=0, out_overflow=0).
- RUN: in_ready=1 while remaining != 0. A beat is accepted when in_valid && in_ready.
  - On accept: pipe <= zero-extended atree output (IN_WIDTH+LEVELS bits); pipe_valid <= 1; remaining decrements.
  - Without accept: pipe_valid <= 0.
  - Whenever pipe_valid=1: {carry, acc} <= acc + pipe; overflow |= carry.
  - The accept that takes remaining from 1 to 0 -> DRAIN.
  - in_valid gaps are allowed and stall only the counter.
- DRAIN: in_ready=0; the last pipe value is added to acc -> DONE. The cycle that enters DRAIN also adds any pipe_valid from the previous beat, so no addition is lost.
- DONE: out_valid=1, out_sum=acc, out_overflow=overflow; all three held stable until out_ready=1. On out_valid && out_ready -> IDLE, and out_valid drops the next cycle.
- Latency: out_valid rises 2 cycles after the edge accepting the last beat. cfg_len=0 gives out_valid 1 cycle after start.
- start is ignored outside IDLE, including in the DONE cycle where out_ready=1. A new start is honoured from the IDLE cycle after the handshake; back-to-back reductions are not overlapped.
- in_ready is never high outside RUN; in_data is ignored when not accepted.
- Arithmetic: all operands unsigned. The tree output is zero-extended to ACC_WIDTH, and the accumulator wraps modulo 2**ACC_WIDTH.

Decomposition:
- Package atree_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} atree_ctrl_state_t
  - the localparam function for NUM_INPUTS (1<<LEVELS)
  - the minimum-ACC_WIDTH check constant
- Sub-modules: one instance of the existing atree (IN_WIDTH, LEVELS passed through) for the combinational reduction. No further sub-module is needed; the FSM, counter, pipe register and accumulator live in this block.

Test Plan:
- Single beat: cfg_len=1, all 16 elements = 1, out_ready=1 -> out_valid 2 cycles after accept, out_sum=16, out_overflow=0, then IDLE/busy=0.
- Max inputs, 3 beats: cfg_len=3, all elements 0xFFFFFFFF -> out_sum=0x2F_FFFF_FFD0, out_overflow=0.
- Stall and backpressure: cfg_len=4, element values 1,2,3,4 per beat (all 16 elements equal), in_valid low 2 cycles between beats, out_ready held low 5 cycles -> out_sum=160, held stable with out_valid=1 until out_ready, exactly 4 accepts.
- Overflow: ACC_WIDTH=36, cfg_len=2, all elements 0xFFFFFFFF -> out_sum=0xF_FFFF_FFE0, out_overflow=1.
- Zero length: start with cfg_len=0 -> out_valid the next cycle, out_sum=0, in_ready never asserted.
- Reset mid-RUN: cfg_len=8, assert rst after 3 accepts -> next cycle IDLE, all outputs 0. A new start with cfg_len=1 and elements=2 gives out_sum=32, with no residue from the aborted run.

Source files
------------

// File: rtl/atree_pkg.sv
// Shared types and elaboration helpers for the adder-tree reduction controller.
package atree_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } atree_ctrl_state_t;

    // Elements per beat for a tree of the given depth.
    function automatic int num_inputs(input int levels);
        return 1 << levels;
    endfunction

    // Narrowest accumulator that can hold one full tree result.
    function automatic int min_acc_width(input int in_width, input int levels);
        return in_width + levels;
    endfunction

endpackage

// File: rtl/atree.sv
// Combinational unsigned adder tree: sums 2**LEVELS elements of IN_WIDTH bits.
// Nodes are stored heap-style: leaves at [N .. 2N-1], root at [1].
module atree
    import atree_pkg::*;
#(
    parameter int IN_WIDTH = 32,
    parameter int LEVELS   = 4
) (
    input  logic [num_inputs(LEVELS)-1:0][IN_WIDTH-1:0] in_data,
    output logic [IN_WIDTH+LEVELS-1:0]                  sum
);

    localparam int N = num_inputs(LEVELS);
    localparam int W = IN_WIDTH + LEVELS;

    logic [W-1:0] w_node [1:2*N-1];

    // Load zero-extended leaves, then fold pairs bottom-up so every node is
    // computed before its parent reads it.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_node[N+i] = {{LEVELS{1'b0}}, in_data[i]};
        end
        for (int i = N - 1; i >= 1; i--) begin
            w_node[i] = w_node[2*i] + w_node[2*i+1];
        end
    end

    assign sum = w_node[1];

endmodule

// File: rtl/atree_accum_ctrl.sv
// Beat-serial reduction sequencer: each accepted beat goes through the adder
// tree into a pipe register, and pipe values are summed into a wide
// accumulator that is presented on a valid/ready result port.
//
//   state | meaning
//   IDLE  | waiting for start; cfg_len latched on start
//   RUN   | accepting beats until the beat count reaches zero
//   DRAIN | folding the last pipe value into the accumulator
//   DONE  | result held on out_* until out_ready
module atree_accum_ctrl
    import atree_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int LEVELS    = 4,
    parameter int ACC_WIDTH = 48,
    parameter int LEN_WIDTH = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [LEN_WIDTH-1:0]                        cfg_len,
    output logic                                        busy,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [num_inputs(LEVELS)-1:0][IN_WIDTH-1:0] in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ACC_WIDTH-1:0]                        out_sum,
    output logic                                        out_overflow
);

    localparam int TREE_W = IN_WIDTH + LEVELS;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    if (ACC_WIDTH < min_acc_width(IN_WIDTH, LEVELS)) begin : g_acc_width_check
        $error("atree_accum_ctrl: ACC_WIDTH must be at least IN_WIDTH+LEVELS");
    end

    atree_ctrl_state_t      r_state;
    atree_ctrl_state_t      w_next;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic [TREE_W-1:0]      r_pipe;
    logic                   r_pipe_valid;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_overflow;
    logic [TREE_W-1:0]      w_tree;
    logic [ACC_WIDTH:0]     w_acc_sum;
    logic                   w_accept;
    logic                   w_launch;

    atree #(
        .IN_WIDTH (IN_WIDTH),
        .LEVELS   (LEVELS)
    ) u_atree (
        .in_data (in_data),
        .sum     (w_tree)
    );

    assign w_accept  = in_valid && in_ready;
    assign w_acc_sum = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_pipe);

    // Result is only driven while presented; zero otherwise.
    assign out_sum      = (r_state == DONE) ? r_acc : '0;
    assign out_overflow = (r_state == DONE) ? r_overflow : 1'b0;

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_launch  = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_launch = 1'b1;
                    w_next   = (cfg_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                in_ready = (r_remaining != '0);
                if (in_valid && (r_remaining == LEN_ONE)) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Beat counter, tree pipe register and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining  <= '0;
            r_pipe       <= '0;
            r_pipe_valid <= 1'b0;
            r_acc        <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe      <= w_tree;
                r_remaining <= r_remaining - LEN_ONE;
            end
            if (w_launch) begin
                r_remaining <= cfg_len;
                r_acc       <= '0;
                r_overflow  <= 1'b0;
            end else if (r_pipe_valid) begin
                r_acc      <= w_acc_sum[ACC_WIDTH-1:0];
                r_overflow <= r_overflow | w_acc_sum[ACC_WIDTH];
            end
        end
    end

endmodule
